// File: rtl/pi1_arbiter_if.sv
// -----------------------------------------------------------------------------
// pi1_arbiter_if
//
// Bundles every pi1 bus signal around the arbiter: the per-master request
// buses (packed, master i occupies slice i), the broadcast read data and
// per-master ready going back to the masters, and the single pi1 port
// towards the shared slave.
//
// Signal names carry the arbiter's point of view (_i = into the arbiter,
// _o = out of the arbiter).
//
// Modports
//   slave  : the arbiter itself. It acts as the slave of the pi1 masters and
//            drives the shared slave port.
//   master : the environment side. It drives the master requests and the
//            shared slave's response.
// -----------------------------------------------------------------------------
interface pi1_arbiter_if #(
  parameter int ARCHBITSZ = 32,
  parameter int MSTRCNT   = 2
);

  localparam int SELSZ     = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELSZ);

  // Master side, packed per master
  logic [2*MSTRCNT-1:0]         m_op_i;
  logic [ADDRBITSZ*MSTRCNT-1:0] m_addr_i;
  logic [ARCHBITSZ*MSTRCNT-1:0] m_data_i;
  logic [SELSZ*MSTRCNT-1:0]     m_sel_i;
  logic [ARCHBITSZ-1:0]         m_data_o;
  logic [MSTRCNT-1:0]           m_rdy_o;

  // Shared slave side
  logic [1:0]                   s_op_o;
  logic [ADDRBITSZ-1:0]         s_addr_o;
  logic [ARCHBITSZ-1:0]         s_data_o;
  logic [SELSZ-1:0]             s_sel_o;
  logic [ARCHBITSZ-1:0]         s_data_i;
  logic                         s_rdy_i;

  modport slave (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i,
    input  s_data_i, s_rdy_i,
    output m_data_o, m_rdy_o,
    output s_op_o, s_addr_o, s_data_o, s_sel_o
  );

  modport master (
    output m_op_i, m_addr_i, m_data_i, m_sel_i,
    output s_data_i, s_rdy_i,
    input  m_data_o, m_rdy_o,
    input  s_op_o, s_addr_o, s_data_o, s_sel_o
  );

endinterface

// File: rtl/pi1_arbiter.sv
// -----------------------------------------------------------------------------
// pi1_arbiter
//
// Shares one pi1 slave between MSTRCNT pi1 masters.
//
// A master requests by driving a non-NOOP op. One requester is selected per
// cycle and its op/addr/data/sel are forwarded to the slave. The slave accepts
// an op on any edge where s_op_o != NOOP and s_rdy_i = 1, and answers on the
// next edge with s_rdy_i = 1. Because of this, the previous owner's response
// and the next master's issue can share one ready cycle. That gives one op per
// cycle when the slave never stalls.
//
// Selection order
//   1. A master that was selected while the slave stalled keeps the bus
//      (hold), as long as it still requests. This keeps s_* stable across a
//      stall.
//   2. Otherwise round-robin: scan last+1, last+2, ... (mod MSTRCNT), where
//      last is the most recently accepted master.
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : synchronous, active-high reset. While it is high all s_* outputs
//            and m_rdy_o are forced to zero.
//   bus    : pi1_arbiter_if.slave
//            m_op_i/m_addr_i/m_data_i/m_sel_i -> per-master requests
//            m_data_o  <- s_data_i, passed straight through to all masters
//            m_rdy_o   <- per-master ready
//            s_op_o/s_addr_o/s_data_o/s_sel_o -> shared slave request
//            s_data_i/s_rdy_i                  <- shared slave response
// -----------------------------------------------------------------------------
module pi1_arbiter #(
  parameter int ARCHBITSZ = 32,  // data width: 16, 32, 64 or 128
  parameter int MSTRCNT   = 2    // number of masters: 2..16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pi1_arbiter_if.slave bus
);

  localparam int SELSZ     = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELSZ);
  localparam int IDXW      = (MSTRCNT > 1) ? $clog2(MSTRCNT) : 1;

  typedef logic [IDXW-1:0] idx_t;

  localparam logic [1:0] OP_NOOP = 2'b00;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic pending_q,  pending_d;   // an accepted op still awaits its response
  idx_t owner_q,    owner_d;     // master that the pending response belongs to
  logic hold_vld_q, hold_vld_d;  // a selection was stalled by the slave
  idx_t hold_idx_q, hold_idx_d;  // master that was stalled
  idx_t last_q,     last_d;      // most recently accepted master (RR pointer)

  // ---------------------------------------------------------------------------
  // Requester set
  // ---------------------------------------------------------------------------
  logic [MSTRCNT-1:0] req;

  always_comb begin
    for (int i = 0; i < MSTRCNT; i++) begin
      req[i] = (bus.m_op_i[2*i +: 2] != OP_NOOP);
    end
  end

  // ---------------------------------------------------------------------------
  // Selection: the held master first, then round-robin after last_q
  // ---------------------------------------------------------------------------
  logic sel_vld;
  idx_t sel_idx;
  idx_t cand;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch.
    // Without that, a path that skips the assignment would infer a latch.
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    if (hold_vld_q && req[hold_idx_q]) begin
      sel_vld = 1'b1;
      sel_idx = hold_idx_q;
    end else begin
      // k runs 1..MSTRCNT, so last_q itself is scanned last.
      for (int k = 1; k <= MSTRCNT; k++) begin
        cand = idx_t'((int'(last_q) + k) % MSTRCNT);
        if (!sel_vld && req[cand]) begin
          sel_vld = 1'b1;
          sel_idx = cand;
        end
      end
    end
  end

  logic accept;
  assign accept = sel_vld && bus.s_rdy_i;

  // ---------------------------------------------------------------------------
  // Outputs: forward the selected master's request to the slave, and route
  // ready to the selected master and to the owner of a pending response
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.s_op_o   = OP_NOOP;
    bus.s_addr_o = '0;
    bus.s_data_o = '0;
    bus.s_sel_o  = '0;
    bus.m_rdy_o  = '0;
    // Read data is a plain broadcast. Each master qualifies it with its own
    // ready bit.
    bus.m_data_o = bus.s_data_i;
    if (!rst_i) begin
      for (int i = 0; i < MSTRCNT; i++) begin
        if (sel_vld && sel_idx == idx_t'(i)) begin
          bus.s_op_o   = bus.m_op_i[2*i +: 2];
          bus.s_addr_o = bus.m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
          bus.s_data_o = bus.m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
          bus.s_sel_o  = bus.m_sel_i[SELSZ*i +: SELSZ];
        end
        // Owner and selection may be the same master. That is the
        // back-to-back case where it gets its response and issues again.
        bus.m_rdy_o[i] = bus.s_rdy_i &&
                         ((sel_vld && sel_idx == idx_t'(i)) ||
                          (pending_q && owner_q == idx_t'(i)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d  = pending_q;
    owner_d    = owner_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;
    last_d     = last_q;
    if (accept) begin
      // The old owner (if any) is answered this cycle, and sel takes over.
      pending_d  = 1'b1;
      owner_d    = sel_idx;
      last_d     = sel_idx;
      hold_vld_d = 1'b0;
    end else if (sel_vld) begin
      // Stalled: remember who was on the bus so s_* stays stable.
      hold_vld_d = 1'b1;
      hold_idx_d = sel_idx;
    end else begin
      // Nobody requests. A withdrawn held master loses its hold.
      hold_vld_d = 1'b0;
      if (bus.s_rdy_i) begin
        pending_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments. Every register then
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= 1'b0;
      owner_q    <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
      // Master 0 is the first candidate after reset.
      last_q     <= idx_t'(MSTRCNT - 1);
    end else begin
      pending_q  <= pending_d;
      owner_q    <= owner_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_pi1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pi1_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle is compared
// against a transaction-level reference model. The model knows only the
// arbitration rules: requesters are masters with a non-NOOP op, a stalled
// master keeps the bus, otherwise round-robin after the last accepted master,
// and the response goes to the owner on the next ready.
// -----------------------------------------------------------------------------
module tb_pi1_arbiter;

  localparam int ARCHBITSZ = 32;
  localparam int MSTRCNT   = 4;
  localparam int SELSZ     = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELSZ);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pi1_arbiter_if #(.ARCHBITSZ(ARCHBITSZ), .MSTRCNT(MSTRCNT)) bus ();

  pi1_arbiter #(.ARCHBITSZ(ARCHBITSZ), .MSTRCNT(MSTRCNT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Stimulus state, one entry per master
  logic [1:0]           op    [MSTRCNT];
  logic [ADDRBITSZ-1:0] addr  [MSTRCNT];
  logic [ARCHBITSZ-1:0] wdata [MSTRCNT];
  logic [SELSZ-1:0]     bsel  [MSTRCNT];
  logic [ARCHBITSZ-1:0] sdata;
  logic                 srdy;

  // Reference model state
  bit mdl_pending;
  int mdl_owner;
  bit mdl_hold;
  int mdl_hold_idx;
  int mdl_last;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    mdl_pending  = 1'b0;
    mdl_owner    = 0;
    mdl_hold     = 1'b0;
    mdl_hold_idx = 0;
    mdl_last     = MSTRCNT - 1;
  endfunction

  // Index of the master that should own the bus this cycle, -1 if none.
  function automatic int model_sel();
    if (mdl_hold && op[mdl_hold_idx] != 2'b00) return mdl_hold_idx;
    for (int k = 1; k <= MSTRCNT; k++) begin
      int c = (mdl_last + k) % MSTRCNT;
      if (op[c] != 2'b00) return c;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < MSTRCNT; i++) begin
      bus.m_op_i[2*i +: 2]                 = op[i];
      bus.m_addr_i[ADDRBITSZ*i +: ADDRBITSZ] = addr[i];
      bus.m_data_i[ARCHBITSZ*i +: ARCHBITSZ] = wdata[i];
      bus.m_sel_i[SELSZ*i +: SELSZ]          = bsel[i];
    end
    bus.s_data_i = sdata;
    bus.s_rdy_i  = srdy;
  endtask

  // Drive the current stimulus, then compare all outputs at the falling edge.
  task automatic look();
    int                   s;
    logic [1:0]           e_op;
    logic [ADDRBITSZ-1:0] e_addr;
    logic [ARCHBITSZ-1:0] e_data;
    logic [SELSZ-1:0]     e_sel;
    logic [MSTRCNT-1:0]   e_rdy;
    apply();
    @(negedge clk);
    e_op = '0; e_addr = '0; e_data = '0; e_sel = '0; e_rdy = '0;
    s = rst ? -1 : model_sel();
    if (s >= 0) begin
      e_op = op[s]; e_addr = addr[s]; e_data = wdata[s]; e_sel = bsel[s];
    end
    if (!rst && srdy) begin
      if (s >= 0) e_rdy[s] = 1'b1;
      if (mdl_pending) e_rdy[mdl_owner] = 1'b1;
    end
    check("s_op",   bus.s_op_o,   e_op);
    check("s_addr", bus.s_addr_o, e_addr);
    check("s_data", bus.s_data_o, e_data);
    check("s_sel",  bus.s_sel_o,  e_sel);
    check("m_rdy",  bus.m_rdy_o,  e_rdy);
    check("m_data", bus.m_data_o, sdata);
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled.
  task automatic advance();
    int s;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s = model_sel();
      if (s >= 0 && srdy) begin
        mdl_pending = 1'b1; mdl_owner = s; mdl_last = s; mdl_hold = 1'b0;
      end else if (s >= 0) begin
        mdl_hold = 1'b1; mdl_hold_idx = s;
      end else begin
        mdl_hold = 1'b0;
        if (srdy) mdl_pending = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step();
    look();
    advance();
  endtask

  task automatic clear_ops();
    for (int i = 0; i < MSTRCNT; i++) op[i] = 2'b00;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; srdy = 1'b0; sdata = '0;
    for (int i = 0; i < MSTRCNT; i++) begin
      op[i] = 2'($urandom_range(3)); addr[i] = ADDRBITSZ'($urandom);
      wdata[i] = $urandom; bsel[i] = SELSZ'($urandom);
    end

    // Reset forces everything quiet, even with requests and slave ready.
    look();
    check("rst_s_op", bus.s_op_o, 2'b00);
    check("rst_m_rdy", bus.m_rdy_o, 4'b0000);
    advance();
    srdy = 1'b1;
    look();
    check("rst_rdy_m_rdy", bus.m_rdy_o, 4'b0000);
    check("rst_s_addr", bus.s_addr_o, 0);
    advance();
    rst = 1'b0; clear_ops();
    step();

    // Two simultaneous requests: m0 first, m1 next, m0's read data with 0011.
    op[0] = 2'b10; addr[0] = 'h10;
    op[1] = 2'b01; addr[1] = 'h20; wdata[1] = 32'h1234_5678;
    look();
    check("r31_first_addr", bus.s_addr_o, 'h10);
    check("r31_first_rdy", bus.m_rdy_o, 4'b0001);
    advance();
    op[0] = 2'b00; sdata = 32'hCAFE_0010;
    look();
    check("r31_second_addr", bus.s_addr_o, 'h20);
    check("r31_both_rdy", bus.m_rdy_o, 4'b0011);
    check("r31_rdata", bus.m_data_o, 32'hCAFE_0010);
    advance();
    op[1] = 2'b00;
    look();
    check("r31_m1_resp", bus.m_rdy_o, 4'b0010);
    advance();

    // A stalled m1 keeps the bus when m0 arrives, even though RR favours m0.
    srdy = 1'b0; op[1] = 2'b01; addr[1] = 'h2222;
    look(); check("r32_c1_addr", bus.s_addr_o, 'h2222); advance();
    op[0] = 2'b10; addr[0] = 'h1111;
    look(); check("r32_c2_addr", bus.s_addr_o, 'h2222); advance();
    look(); check("r32_c3_addr", bus.s_addr_o, 'h2222); check("r32_c3_rdy", bus.m_rdy_o, 4'b0000); advance();
    srdy = 1'b1;
    look(); check("r32_acc_m1", bus.s_addr_o, 'h2222); check("r32_acc_m1_rdy", bus.m_rdy_o, 4'b0010); advance();
    op[1] = 2'b00;
    look(); check("r32_acc_m0", bus.s_addr_o, 'h1111); check("r32_acc_m0_rdy", bus.m_rdy_o, 4'b0011); advance();
    op[0] = 2'b00;
    look(); check("r32_m0_resp", bus.m_rdy_o, 4'b0001); advance();

    // Response held off by a slave stall for two cycles.
    op[0] = 2'b10; addr[0] = 'h34;
    look(); check("r34_acc", bus.m_rdy_o, 4'b0001); advance();
    op[0] = 2'b00; srdy = 1'b0;
    look(); check("r34_wait1", bus.m_rdy_o, 4'b0000); advance();
    look(); check("r34_wait2", bus.m_rdy_o, 4'b0000); advance();
    srdy = 1'b1;
    look(); check("r34_resp", bus.m_rdy_o, 4'b0001); advance();
    look(); check("r34_cleared", bus.m_rdy_o, 4'b0000); advance();

    // Withdrawal while held releases the hold.
    srdy = 1'b0; op[2] = 2'b01; addr[2] = 'h2020;
    look(); check("wd_held_m2", bus.s_addr_o, 'h2020); advance();
    op[2] = 2'b00; op[3] = 2'b10; addr[3] = 'h3030;
    look(); check("wd_switch_m3", bus.s_addr_o, 'h3030); advance();
    srdy = 1'b1;
    look(); check("wd_acc_m3", bus.m_rdy_o, 4'b1000); advance();
    op[3] = 2'b00;
    look(); check("wd_resp_m3", bus.m_rdy_o, 4'b1000); advance();

    // Reset while a response is pending: the old owner is never signalled.
    op[0] = 2'b10; addr[0] = 'h40;
    look(); check("r35_acc_m0", bus.m_rdy_o, 4'b0001); advance();
    rst = 1'b1; op[1] = 2'b01;
    look();
    check("r35_rst_op", bus.s_op_o, 2'b00);
    check("r35_rst_addr", bus.s_addr_o, 0);
    check("r35_rst_data", bus.s_data_o, 0);
    check("r35_rst_sel", bus.s_sel_o, 0);
    check("r35_rst_rdy", bus.m_rdy_o, 4'b0000);
    advance();
    rst = 1'b0; op[0] = 2'b00; addr[1] = 'h5150;
    look(); check("r35_post_addr", bus.s_addr_o, 'h5150); check("r35_post_rdy", bus.m_rdy_o, 4'b0010); advance();
    clear_ops();
    step();

    // All four masters requesting continuously: strict 0,1,2,3 rotation.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < MSTRCNT; i++) begin
      op[i] = 2'($urandom_range(3, 1)); addr[i] = ADDRBITSZ'('h100 + i);
    end
    for (int k = 0; k < 12; k++) begin
      logic [MSTRCNT-1:0] e_rdy;
      e_rdy = '0;
      e_rdy[k % MSTRCNT] = 1'b1;
      if (k > 0) e_rdy[(k - 1) % MSTRCNT] = 1'b1;
      look();
      check("r33_order", bus.s_addr_o, 'h100 + (k % MSTRCNT));
      check("r33_rdy", bus.m_rdy_o, e_rdy);
      advance();
    end

    // Randomized traffic with stalls and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(99) == 0);
      srdy  = ($urandom_range(9) < 7);
      sdata = $urandom;
      for (int i = 0; i < MSTRCNT; i++) begin
        if ($urandom_range(1) == 0) begin
          op[i]    = ($urandom_range(2) == 0) ? 2'b00 : 2'($urandom_range(3));
          addr[i]  = ADDRBITSZ'($urandom);
          wdata[i] = $urandom;
          bsel[i]  = SELSZ'($urandom);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pi1_arbiter.md
PI1_ARBITER -- requirements
Module: pi1_arbiter

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, data width in bits (16, 32, 64 or 128).
REQ-002 SHALL have parameter MSTRCNT, default 2, number of pi1 masters (2..16).
REQ-003 SHALL derive ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8) and SELSZ = ARCHBITSZ/8.
REQ-004 SHALL have port rst_i, input, 1 bit; one clock, reset synchronous, active-high.
REQ-005 SHALL have port clk_i, input, 1 bit; sole clock, rising edge.
REQ-006 SHALL have port m_op_i, input, 2*MSTRCNT, per-master op; slice i = bits [2*i+1:2*i].
REQ-007 SHALL have port m_addr_i, input, ADDRBITSZ*MSTRCNT, per-master word address.
REQ-008 SHALL have port m_data_i, input, ARCHBITSZ*MSTRCNT, per-master write data.
REQ-009 SHALL have port m_sel_i, input, SELSZ*MSTRCNT, per-master byte select.
REQ-010 SHALL have port m_data_o, output, ARCHBITSZ, read data broadcast to all masters.
REQ-011 SHALL have port m_rdy_o, output, MSTRCNT, per-master ready.
REQ-012 SHALL have ports s_op_o (2), s_addr_o (ADDRBITSZ), s_data_o (ARCHBITSZ), s_sel_o (SELSZ), all outputs to the shared slave.
REQ-013 SHALL have ports s_data_i (ARCHBITSZ) and s_rdy_i (1), inputs from the shared slave.

Function
REQ-014 SHALL use pi1 op encoding: 00 NOOP, 01 WRITE, 10 READ, 11 READ-WRITE (swap).
REQ-015 SHALL treat a slave op as accepted on a rising edge where s_op_o != 00 and s_rdy_i = 1; its response is due at the next edge with s_rdy_i = 1.
REQ-016 SHALL hold state: pending (1b), owner (clog2 MSTRCNT), hold_vld (1b), hold_idx, last (round-robin pointer).
REQ-017 SHALL drive m_data_o = s_data_i combinationally, unregistered.
REQ-018 SHALL compute a requester set R = {i : m_op_i slice i != 00}.
REQ-019 SHALL select sel = hold_idx when hold_vld = 1 and hold_idx is in R; otherwise the first member of R scanning last+1, last+2, ... modulo MSTRCNT; otherwise none.
REQ-020 SHALL forward op/addr/data/sel of sel to the s_* outputs when a selection exists; otherwise s_op_o = 00 and s_addr_o/s_data_o/s_sel_o = 0.
REQ-021 SHALL drive m_rdy_o[i] = s_rdy_i when i = sel, or when pending = 1 and i = owner; all other bits 0.
REQ-022 On an edge where a selected op is accepted, SHALL set pending <= 1, owner <= sel, last <= sel, hold_vld <= 0.
REQ-023 On an edge where a selected op exists and s_rdy_i = 0, SHALL set hold_vld <= 1 and hold_idx <= sel, leaving pending, owner and last unchanged.
REQ-024 On an edge with s_rdy_i = 1 and no selection, SHALL set pending <= 0 and hold_vld <= 0.
REQ-025 Simultaneous response and issue SHALL be legal: in one s_rdy_i = 1 cycle, owner p receives its response while sel q (q = p allowed) is accepted, giving back-to-back throughput of 1 op/cycle.
REQ-026 A master withdrawing its op while held SHALL release the hold; the next selection is round-robin per REQ-019 with no error flagged.
REQ-027 No starvation: with all MSTRCNT masters requesting continuously, each SHALL be accepted exactly once in every MSTRCNT consecutive acceptances.

Reset
REQ-028 While rst_i = 1, SHALL force s_op_o = 00, s_addr_o/s_data_o/s_sel_o = 0 and m_rdy_o = 0.
REQ-029 On reset, SHALL set pending = 0, hold_vld = 0, owner = 0, hold_idx = 0 and last = MSTRCNT-1, so master 0 has first priority.
REQ-030 A reset asserted mid-operation SHALL discard the pending response; the first post-reset s_rdy_i cycle SHALL assert no m_rdy_o bit for an old owner.

Verification
REQ-031 MSTRCNT=2, s_rdy_i=1: m0 READ addr 0x10 and m1 WRITE addr 0x20 asserted at the same time -> m0 accepted first, m1 in the next cycle, and m0's s_data_i is seen on m_data_o in the cycle m_rdy_o = 2'b11.
REQ-032 m1 op presented with s_rdy_i=0 for 3 cycles, m0 op raised in cycle 2 -> s_addr_o stays m1's for all 3 cycles; m1 accepted, then m0.
REQ-033 MSTRCNT=4, all masters requesting continuously, s_rdy_i=1 -> acceptance order 0,1,2,3,0,1,... with 1 acceptance per cycle.
REQ-034 m0 READ accepted, s_rdy_i=0 for 2 cycles, then 1 -> m_rdy_o[0]=1 only in the cycle s_rdy_i=1; pending clears if no new op.
REQ-035 rst_i pulsed for 1 cycle while pending=1 -> all outputs 0 during reset; post-reset, the first request from m1 alone is accepted with m_rdy_o = 2'b10 and nothing is signalled to the old owner.
